// File: rtl/water_inlet_arbiter.sv
// water_inlet_arbiter: round-robin owner of one metered mains inlet valve shared by NUM_MACHINES fill stages.
// Define WATCHDOG_EN to release a grant paused for MAX_PAUSE cycles and pulse timeout_o.
module water_inlet_arbiter #(
  parameter int NUM_MACHINES  = 4,
  parameter int FILL_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_PAUSE     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MACHINES-1:0]         req_i,
  input  logic [NUM_MACHINES-1:0]         pause_i,
  output logic [NUM_MACHINES-1:0]         grant_o,
  output logic                            valve_open_o,
  output logic [NUM_MACHINES-1:0]         fill_done_o,
  output logic [$clog2(NUM_MACHINES)-1:0] active_id_o,
  output logic                            busy_o,
  output logic [NUM_MACHINES-1:0]         timeout_o
);
  localparam int IW = $clog2(NUM_MACHINES);
  localparam int FW = $clog2(FILL_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  if (NUM_MACHINES < 2 || NUM_MACHINES > 8 || FILL_CYCLES < 1 || SETTLE_CYCLES < 1 || MAX_PAUSE < 1) begin : g_bad_params
    $error("water_inlet_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, OPEN, SETTLE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_MACHINES-1:0] grant_q, grant_d, done_q, done_d;
  logic                    valve_q, valve_d;
  logic [IW-1:0]           id_q, id_d, rr_q, rr_d, pick;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic [SW-1:0]           scnt_q, scnt_d;
  logic                    cur_req, cur_pause, fill_end, settle_end, wd_end, leave;

  assign cur_req    = req_i[id_q];
  assign cur_pause  = pause_i[id_q];
  assign fill_end   = valve_q && fcnt_q == FW'(FILL_CYCLES - 1);
  assign settle_end = scnt_q == SW'(SETTLE_CYCLES);
  assign leave      = !cur_req || wd_end || (!cur_pause && fill_end);

  // Later candidates are overwritten by nearer ones, so the first set bit after rr_q wins.
  always_comb begin
    pick = '0;
    for (int k = NUM_MACHINES; k >= 1; k--)
      if (req_i[IW'((int'(rr_q) + k) % NUM_MACHINES)]) pick = IW'((int'(rr_q) + k) % NUM_MACHINES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valve_q <= 1'b0;
      done_q  <= '0;
      id_q    <= '0;
      rr_q    <= IW'(NUM_MACHINES - 1);
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valve_q <= valve_d;
      done_q  <= done_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb
    state_d = state_q == IDLE   ? (|req_i ? OPEN : IDLE) :
              state_q == OPEN   ? (leave ? SETTLE : OPEN) :
              state_q == SETTLE ? (settle_end ? IDLE : SETTLE) : IDLE;

  // Abort beats watchdog, watchdog beats pause, pause beats fill completion.
  always_comb begin
    grant_d = '0;
    valve_d = 1'b0;
    done_d  = '0;
    id_d    = id_q;
    rr_d    = rr_q;
    fcnt_d  = '0;
    scnt_d  = '0;
    if (state_q == IDLE && |req_i) begin
      grant_d = NUM_MACHINES'(1) << pick;
      valve_d = !pause_i[pick];
      id_d    = pick;
      rr_d    = pick;
    end else if (state_q == OPEN && cur_req && !wd_end) begin
      if (cur_pause) begin
        grant_d = grant_q;
        fcnt_d  = fcnt_q;
      end else if (fill_end) begin
        done_d = grant_q;
      end else begin
        grant_d = grant_q;
        valve_d = 1'b1;
        fcnt_d  = fcnt_q + FW'(valve_q);
      end
    end else if (state_q == SETTLE) begin
      scnt_d = scnt_q + SW'(1);
    end
  end

`ifdef WATCHDOG_EN
  localparam int PW = $clog2(MAX_PAUSE + 1);
  logic [PW-1:0]           pcnt_q;
  logic [NUM_MACHINES-1:0] tmo_q;
  assign wd_end = state_q == OPEN && cur_req && cur_pause && pcnt_q == PW'(MAX_PAUSE - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      tmo_q  <= '0;
    end else begin
      pcnt_q <= (state_q == OPEN && cur_pause && !wd_end) ? pcnt_q + PW'(1) : '0;
      tmo_q  <= wd_end ? grant_q : '0;
    end
  end
  assign timeout_o = tmo_q;
`else
  assign wd_end    = 1'b0;
  assign timeout_o = '0;
`endif

  assign grant_o      = grant_q;
  assign valve_open_o = valve_q;
  assign fill_done_o  = done_q;
  assign active_id_o  = id_q;
  assign busy_o       = state_q != IDLE;
endmodule

// File: tb/tb_water_inlet_arbiter.sv
// tb_water_inlet_arbiter: directed test-plan scenarios plus random req/pause/reset traffic against a cycle model.
module tb_water_inlet_arbiter;
  localparam int N = 4, FILL = 8, SETTLE = 2, MAXP = 16;
`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, pause = '0;
  logic [N-1:0] grant, fill_done, timeout;
  logic [1:0] active_id;
  logic valve_open, busy;
  int errors = 0, checks = 0;

  // Model: owner (-1 = none), water delivered, cooldown cycles left before arbitration resumes.
  int m_owner, m_last, m_id, m_deliv, m_cool, m_prun;
  bit m_valve;
  logic [N-1:0] m_done, m_tmo;

  water_inlet_arbiter #(.NUM_MACHINES(N), .FILL_CYCLES(FILL), .SETTLE_CYCLES(SETTLE), .MAX_PAUSE(MAXP)) dut (
    .clk(clk), .rst(rst), .req_i(req), .pause_i(pause), .grant_o(grant), .valve_open_o(valve_open),
    .fill_done_o(fill_done), .active_id_o(active_id), .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_last = N - 1; m_id = 0; m_deliv = 0; m_cool = 0; m_prun = 0;
    m_valve = 1'b0; m_done = '0; m_tmo = '0;
  endfunction

  function automatic void release_m();
    m_owner = -1; m_valve = 1'b0; m_cool = SETTLE + 1; m_prun = 0;
  endfunction

  function automatic void model_step();
    m_done = '0; m_tmo = '0;
    if (m_owner < 0) begin
      if (m_cool > 0) m_cool--;
      else if (req != '0) begin
        for (int k = 1; k <= N; k++)
          if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
        m_id = m_owner; m_last = m_owner; m_deliv = 0; m_prun = 0; m_valve = !pause[m_owner];
      end
    end else if (!req[m_owner]) release_m();
    else if (WD && pause[m_owner] && m_prun == MAXP - 1) begin
      m_tmo[m_owner] = 1'b1; release_m();
    end else if (pause[m_owner]) begin
      m_valve = 1'b0; m_prun++;
    end else if (m_valve && m_deliv == FILL - 1) begin
      m_done[m_owner] = 1'b1; release_m();
    end else begin
      m_deliv += int'(m_valve); m_valve = 1'b1; m_prun = 0;
    end
  endfunction

  task automatic compare();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("grant", grant, eg);
    check("valve_open", valve_open, m_valve);
    check("fill_done", fill_done, m_done);
    check("timeout", timeout, m_tmo);
    check("active_id", active_id, m_id);
    check("busy", busy, m_owner >= 0 || m_cool > 0);
    check("grant_onehot", $countones(grant) <= 1, 1);
    check("valve_needs_grant", !valve_open || grant != '0, 1);
    check("done_not_granted", (fill_done & grant) == '0, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1 compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 model_reset();
    compare();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    req = '0;
    pause = '0;
    for (int i = 0; i < 20 && busy; i++) tick();
    check("idle_reached", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, n_open, done_at, held, dropped, dones, next_at, tmo_at;
    logic [N-1:0] prev;
    int order[$];

    // single fill
    do_reset();
    req = 4'b0001; c = 0; n_open = 0; done_at = -1;
    for (int i = 0; i < 30 && done_at < 0; i++) begin
      tick(); c++;
      if (c == 1) check("t1_grant", grant, 4'b0001);
      if (valve_open) n_open++;
      if (fill_done[0]) begin done_at = c; req = '0; end
    end
    check("t1_open_cycles", n_open, FILL);
    check("t1_done_at", done_at, 9);
    while (busy && c < 40) begin tick(); c++; end
    check("t1_idle_at", c, 12);

    // round robin with all requests held
    do_reset();
    req = '1; prev = '0;
    for (int i = 0; i < 80 && order.size() < 5; i++) begin
      tick();
      if (grant != '0 && prev == '0) order.push_back(int'(active_id));
      prev = grant;
    end
    check("t2_grants", order.size(), 5);
    for (int i = 0; i < order.size(); i++) check("t2_order", order[i], i % N);
    wait_idle();

    // pause in the middle of a fill
    do_reset();
    req = 4'b0100; c = 0; held = 0; done_at = -1;
    for (int i = 0; i < 40 && done_at < 0; i++) begin
      tick(); c++;
      if (c == 4) pause[2] = 1'b1;
      if (c == 9) pause[2] = 1'b0;
      if (grant == 4'b0100) held++;
      if (fill_done[2]) begin done_at = c; req = '0; end
    end
    check("t3_done_at", done_at, 15);
    check("t3_grant_held", held, 14);
    wait_idle();

    // abort then hand-over to the next requester
    do_reset();
    req = 4'b1010; c = 0; dropped = -1; dones = 0; next_at = -1;
    for (int i = 0; i < 20 && next_at < 0; i++) begin
      tick(); c++;
      if (c == 1) check("t4_grant", grant, 4'b0010);
      if (c == 4) req[1] = 1'b0;
      if (grant == '0 && dropped < 0 && c > 1) dropped = c;
      if (fill_done != '0) dones++;
      if (grant == 4'b1000) next_at = c;
    end
    check("t4_release_at", dropped, 5);
    check("t4_no_done", dones, 0);
    check("t4_next_at", next_at, 9);
    wait_idle();

    // asynchronous reset during a fill
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    check("t5_open_before", valve_open, 1);
    rst = 1'b1;
    #1;
    check("t5_grant_async", grant, 0);
    check("t5_valve_async", valve_open, 0);
    check("t5_busy_async", busy, 0);
    model_reset();
    compare();
    tick();
    rst = 1'b0;
    tick();
    check("t5_regrant", grant, 4'b0001);
    wait_idle();

    // long pause: watchdog releases, otherwise the grant is held
    do_reset();
    req = 4'b0001; c = 0; held = 0; tmo_at = -1;
    for (int i = 0; i < 22; i++) begin
      tick(); c++;
      if (c == 2) pause[0] = 1'b1;
      if (c >= 3 && grant == 4'b0001) held++;
      if (timeout[0] && tmo_at < 0) begin tmo_at = c; req = '0; end
    end
    check("t6_timeout_at", tmo_at, WD ? 18 : -1);
    check("t6_grant_held", held, WD ? 15 : 20);
    wait_idle();

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(15) == 0) req[m] = ~req[m];
        if ($urandom_range(9) == 0) pause[m] = ~pause[m];
        if (fill_done[m] && $urandom_range(1) == 1) req[m] = 1'b0;
      end
      if ($urandom_range(599) == 0) do_reset(); else tick();
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
